// File: rtl/pipeline_exe_mem_elastic.sv
// ---------------------------------------------------------------------------
// pipeline_exe_mem_elastic
//
// Elastic EXE->MEM pipeline stage. The execute-stage datapath and control
// bundle travel into the memory stage over a valid/ready handshake. A
// two-entry buffer (head + skid) lets MEM stall without a combinational
// ready path back into EXE: ReadyE comes straight off the skid valid flop.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous kill of everything held or accepted now
//   ValidE / ReadyE   upstream handshake (ReadyE = !skid valid, registered)
//   *E                execute-stage payload: ALUResultE, WriteDataE,
//                     PCPlus4E, RdE, RegWriteE, ResultSrcE, AddrModeE, WD3SrcE
//   ValidM / ReadyM   downstream handshake for the head entry
//   *M                head-entry payload; RegWriteM is gated by ValidM
//   Occupancy         number of entries held (0..2)
// ---------------------------------------------------------------------------
module pipeline_exe_mem_elastic #(
   parameter int WIDTH = 32,
   parameter int RD_W  = 5,
   parameter int AM_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             ValidE,
   output logic             ReadyE,
   input  logic [WIDTH-1:0] ALUResultE,
   input  logic [WIDTH-1:0] WriteDataE,
   input  logic [WIDTH-1:0] PCPlus4E,
   input  logic [RD_W-1:0]  RdE,
   input  logic             RegWriteE,
   input  logic             ResultSrcE,
   input  logic [AM_W-1:0]  AddrModeE,
   input  logic             WD3SrcE,
   output logic             ValidM,
   input  logic             ReadyM,
   output logic [WIDTH-1:0] ALUResultM,
   output logic [WIDTH-1:0] WriteDataM,
   output logic [WIDTH-1:0] PCPlus4M,
   output logic [RD_W-1:0]  RdM,
   output logic             RegWriteM,
   output logic             ResultSrcM,
   output logic [AM_W-1:0]  AddrModeM,
   output logic             WD3SrcM,
   output logic [1:0]       Occupancy
);

   // Whole bundle is moved as one packed word; fields are pure pass-through.
   localparam int PW = 3*WIDTH + RD_W + AM_W + 3;

   logic [PW-1:0] in_beat;
   logic [PW-1:0] main_reg;
   logic [PW-1:0] skid_reg;
   logic          main_valid_reg;
   logic          skid_valid_reg;

   logic          main_valid_next;
   logic          skid_valid_next;
   logic          load_main_from_in;
   logic          load_main_from_skid;
   logic          load_skid;
   logic          accept;
   logic          consume;
   logic          head_regwrite;

   assign in_beat = {ALUResultE, WriteDataE, PCPlus4E, RdE,
                     RegWriteE, ResultSrcE, AddrModeE, WD3SrcE};

   // Skid only fills when the head is stuck, so "skid empty" is exactly
   // "there is room for one more beat" and needs no look at ReadyM.
   assign ReadyE  = ~skid_valid_reg;
   assign accept  = ValidE & ReadyE;
   assign consume = main_valid_reg & ReadyM;

   always_comb begin
      load_main_from_in   = 1'b0;
      load_main_from_skid = 1'b0;
      load_skid           = 1'b0;
      main_valid_next     = main_valid_reg;
      skid_valid_next     = skid_valid_reg;

      if (flush) begin
         // Entries and this cycle's beat are dropped; a head that MEM takes
         // this cycle has already left, so nothing more to do for it.
         main_valid_next = 1'b0;
         skid_valid_next = 1'b0;
      end else if (skid_valid_reg) begin
         // Full: ReadyE is low, so only the consume side can move.
         if (consume) begin
            load_main_from_skid = 1'b1;
            skid_valid_next     = 1'b0;
         end
      end else if (main_valid_reg) begin
         if (accept && consume) begin
            load_main_from_in = 1'b1;
         end else if (accept) begin
            load_skid       = 1'b1;
            skid_valid_next = 1'b1;
         end else if (consume) begin
            main_valid_next = 1'b0;
         end
      end else if (accept) begin
         load_main_from_in = 1'b1;
         main_valid_next   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         main_reg       <= '0;
         skid_reg       <= '0;
      end else begin
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
         if (load_main_from_skid) begin
            main_reg <= skid_reg;
         end else if (load_main_from_in) begin
            main_reg <= in_beat;
         end
         if (load_skid) begin
            skid_reg <= in_beat;
         end
      end
   end

   assign {ALUResultM, WriteDataM, PCPlus4M, RdM,
           head_regwrite, ResultSrcM, AddrModeM, WD3SrcM} = main_reg;

   assign ValidM    = main_valid_reg;
   // A dead head must never look like a pending register write to the
   // forwarding/hazard logic, even though its payload may be stale.
   assign RegWriteM = main_valid_reg & head_regwrite;
   assign Occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

   // The skid can only hold a beat behind a valid head; otherwise the
   // occupancy count would be meaningless (3 is never legal).
   a_occupancy_legal : assert property (@(posedge clk) disable iff (!rst_n)
      (Occupancy != 2'd3) && (!skid_valid_reg || main_valid_reg))
      else $error("illegal occupancy %0d", Occupancy);

endmodule

// File: tb/tb_pipeline_exe_mem_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipeline_exe_mem_elastic
//
// Self-checking bench for pipeline_exe_mem_elastic (WIDTH=64, RD_W=6).
// Directed table of cycles with hand-derived expectations, a hand-written
// asynchronous reset sequence, then randomized traffic checked every cycle
// against a FIFO-of-beats reference model (capacity 2).
// ---------------------------------------------------------------------------
module tb_pipeline_exe_mem_elastic;

   localparam int WIDTH = 64;
   localparam int RD_W  = 6;
   localparam int AM_W  = 3;

   typedef struct packed {
      logic [WIDTH-1:0] alu;
      logic [WIDTH-1:0] wd;
      logic [WIDTH-1:0] pc;
      logic [RD_W-1:0]  rd;
      logic             rw;
      logic             rs;
      logic [AM_W-1:0]  am;
      logic             wd3;
   } beat_t;

   typedef struct packed {
      logic        v;
      logic        r;
      logic        f;
      logic [63:0] alu;
      logic [5:0]  rd;
      logic        rw;
      logic        exp_vm;
      logic        exp_re;
      logic [1:0]  exp_occ;
      logic [63:0] exp_alu;
      logic [5:0]  exp_rd;
      logic        exp_rw;
   } vec_t;

   logic clk;
   logic rst_n;
   logic flush;
   logic ValidE;
   logic ReadyM;
   beat_t cur;

   logic             ReadyE;
   logic             ValidM;
   logic [WIDTH-1:0] ALUResultM;
   logic [WIDTH-1:0] WriteDataM;
   logic [WIDTH-1:0] PCPlus4M;
   logic [RD_W-1:0]  RdM;
   logic             RegWriteM;
   logic             ResultSrcM;
   logic [AM_W-1:0]  AddrModeM;
   logic             WD3SrcM;
   logic [1:0]       Occupancy;

   int total;
   int bad;

   beat_t q[$];        // reference model: beats held, head first
   logic  model_acc;
   logic  model_con;
   logic  last_acc;

   vec_t  tbl[19];

   pipeline_exe_mem_elastic #(.WIDTH(WIDTH), .RD_W(RD_W), .AM_W(AM_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .ValidE     (ValidE),
      .ReadyE     (ReadyE),
      .ALUResultE (cur.alu),
      .WriteDataE (cur.wd),
      .PCPlus4E   (cur.pc),
      .RdE        (cur.rd),
      .RegWriteE  (cur.rw),
      .ResultSrcE (cur.rs),
      .AddrModeE  (cur.am),
      .WD3SrcE    (cur.wd3),
      .ValidM     (ValidM),
      .ReadyM     (ReadyM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RdM        (RdM),
      .RegWriteM  (RegWriteM),
      .ResultSrcM (ResultSrcM),
      .AddrModeM  (AddrModeM),
      .WD3SrcM    (WD3SrcM),
      .Occupancy  (Occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic r, input logic f,
                               input logic [63:0] alu, input logic [5:0] rd,
                               input logic rw, input logic evm, input logic ere,
                               input logic [1:0] eocc, input logic [63:0] ealu,
                               input logic [5:0] erd, input logic erw);
      vec_t t;
      t.v = v; t.r = r; t.f = f; t.alu = alu; t.rd = rd; t.rw = rw;
      t.exp_vm = evm; t.exp_re = ere; t.exp_occ = eocc;
      t.exp_alu = ealu; t.exp_rd = erd; t.exp_rw = erw;
      return t;
   endfunction

   // One clock: decide what the model does from the inputs held during the
   // cycle, let the edge pass, then apply it. Outputs are read 1 time unit
   // after the edge.
   task automatic cycle();
      model_acc = ValidE && (q.size() < 2);
      model_con = (q.size() > 0) && ReadyM;
      @(posedge clk);
      #1;
      if (flush) begin
         q.delete();
      end else begin
         if (model_con) void'(q.pop_front());
         if (model_acc) q.push_back(cur);
      end
      last_acc = model_acc;
   endtask

   task automatic check_model(input string tag);
      logic [63:0] exp_rw;
      chk({tag, ".ValidM"}, {63'd0, ValidM}, {63'd0, q.size() > 0});
      chk({tag, ".ReadyE"}, {63'd0, ReadyE}, {63'd0, q.size() < 2});
      chk({tag, ".Occupancy"}, {62'd0, Occupancy}, 64'(q.size()));
      exp_rw = (q.size() > 0) ? {63'd0, q[0].rw} : 64'd0;
      chk({tag, ".RegWriteM"}, {63'd0, RegWriteM}, exp_rw);
      if (q.size() > 0) begin
         chk({tag, ".ALUResultM"}, ALUResultM, q[0].alu);
         chk({tag, ".WriteDataM"}, WriteDataM, q[0].wd);
         chk({tag, ".PCPlus4M"}, PCPlus4M, q[0].pc);
         chk({tag, ".RdM"}, {58'd0, RdM}, {58'd0, q[0].rd});
         chk({tag, ".ResultSrcM"}, {63'd0, ResultSrcM}, {63'd0, q[0].rs});
         chk({tag, ".AddrModeM"}, {61'd0, AddrModeM}, {61'd0, q[0].am});
         chk({tag, ".WD3SrcM"}, {63'd0, WD3SrcM}, {63'd0, q[0].wd3});
      end
   endtask

   function automatic beat_t rand_beat();
      beat_t b;
      b.alu = {$urandom, $urandom};
      b.wd  = {$urandom, $urandom};
      b.pc  = {$urandom, $urandom};
      b.rd  = 6'($urandom);
      b.rw  = 1'($urandom);
      b.rs  = 1'($urandom);
      b.am  = 3'($urandom);
      b.wd3 = 1'($urandom);
      return b;
   endfunction

   initial begin
      total = 0;
      bad = 0;
      last_acc = 1'b1;
      rst_n = 1'b0;
      flush = 1'b0;
      ValidE = 1'b0;
      ReadyM = 1'b0;
      cur = '0;

      tbl[0]  = mk(1,1,0,64'h10,6'd1,1,  1,1,2'd1,64'h10,6'd1,1);
      tbl[1]  = mk(1,1,0,64'h20,6'd2,1,  1,1,2'd1,64'h20,6'd2,1);
      tbl[2]  = mk(1,1,0,64'h30,6'd3,1,  1,1,2'd1,64'h30,6'd3,1);
      tbl[3]  = mk(1,1,0,64'h40,6'd4,1,  1,1,2'd1,64'h40,6'd4,1);
      tbl[4]  = mk(0,1,0,64'h0,6'd0,0,   0,1,2'd0,64'h0,6'd0,0);
      tbl[5]  = mk(1,1,0,64'h50,6'd8,1,  1,1,2'd1,64'h50,6'd8,1);
      tbl[6]  = mk(0,1,0,64'h99,6'd9,1,  0,1,2'd0,64'h0,6'd0,0);
      tbl[7]  = mk(1,1,0,64'h60,6'd10,1, 1,1,2'd1,64'h60,6'd10,1);
      tbl[8]  = mk(0,1,0,64'h0,6'd0,0,   0,1,2'd0,64'h0,6'd0,0);
      tbl[9]  = mk(1,0,0,64'hA0,6'd5,1,  1,1,2'd1,64'hA0,6'd5,1);
      tbl[10] = mk(1,0,0,64'hB0,6'd6,0,  1,0,2'd2,64'hA0,6'd5,1);
      tbl[11] = mk(1,0,0,64'hC0,6'd7,1,  1,0,2'd2,64'hA0,6'd5,1);
      tbl[12] = mk(1,1,0,64'hC0,6'd7,1,  1,1,2'd1,64'hB0,6'd6,0);
      tbl[13] = mk(1,1,0,64'hC0,6'd7,1,  1,1,2'd1,64'hC0,6'd7,1);
      tbl[14] = mk(0,1,0,64'h0,6'd0,0,   0,1,2'd0,64'h0,6'd0,0);
      tbl[15] = mk(1,0,0,64'hD0,6'd11,1, 1,1,2'd1,64'hD0,6'd11,1);
      tbl[16] = mk(1,0,0,64'hE0,6'd12,1, 1,0,2'd2,64'hD0,6'd11,1);
      tbl[17] = mk(1,0,1,64'hF0,6'd13,1, 0,1,2'd0,64'h0,6'd0,0);
      tbl[18] = mk(0,1,0,64'h0,6'd0,0,   0,1,2'd0,64'h0,6'd0,0);

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst.ValidM", {63'd0, ValidM}, 64'd0);
      chk("rst.Occupancy", {62'd0, Occupancy}, 64'd0);
      chk("rst.RegWriteM", {63'd0, RegWriteM}, 64'd0);
      chk("rst.ALUResultM", ALUResultM, 64'd0);
      chk("rst.RdM", {58'd0, RdM}, 64'd0);
      rst_n = 1'b1;
      cycle();
      chk("rst.ReadyE", {63'd0, ReadyE}, 64'd1);

      // ---- directed table ----
      for (int i = 0; i < 19; i++) begin
         ValidE = tbl[i].v;
         ReadyM = tbl[i].r;
         flush  = tbl[i].f;
         cur    = '0;
         cur.alu = tbl[i].alu;
         cur.wd  = tbl[i].alu ^ 64'h5555;
         cur.pc  = tbl[i].alu + 64'd4;
         cur.rd  = tbl[i].rd;
         cur.rw  = tbl[i].rw;
         cycle();
         chk($sformatf("tbl%0d.ValidM", i), {63'd0, ValidM}, {63'd0, tbl[i].exp_vm});
         chk($sformatf("tbl%0d.ReadyE", i), {63'd0, ReadyE}, {63'd0, tbl[i].exp_re});
         chk($sformatf("tbl%0d.Occupancy", i), {62'd0, Occupancy}, {62'd0, tbl[i].exp_occ});
         chk($sformatf("tbl%0d.RegWriteM", i), {63'd0, RegWriteM}, {63'd0, tbl[i].exp_rw});
         if (tbl[i].exp_vm) begin
            chk($sformatf("tbl%0d.ALUResultM", i), ALUResultM, tbl[i].exp_alu);
            chk($sformatf("tbl%0d.RdM", i), {58'd0, RdM}, {58'd0, tbl[i].exp_rd});
         end
         $display("tbl %0d: ValidM=%0b ReadyE=%0b Occ=%0d ALUResultM=%h", i, ValidM, ReadyE, Occupancy, ALUResultM);
      end
      flush = 1'b0;

      // ---- asynchronous reset with two entries held ----
      ReadyM = 1'b0;
      ValidE = 1'b1;
      cur = rand_beat();
      cur.wd = 64'hDEADBEEF;
      cur.rw = 1'b1;
      cur.am = 3'd5;
      cycle();
      cur = rand_beat();
      cycle();
      chk("arst.pre.Occupancy", {62'd0, Occupancy}, 64'd2);
      chk("arst.pre.WriteDataM", WriteDataM, 64'hDEADBEEF);
      ValidE = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst.ValidM", {63'd0, ValidM}, 64'd0);
      chk("arst.Occupancy", {62'd0, Occupancy}, 64'd0);
      chk("arst.RegWriteM", {63'd0, RegWriteM}, 64'd0);
      chk("arst.WriteDataM", WriteDataM, 64'd0);
      chk("arst.ALUResultM", ALUResultM, 64'd0);
      chk("arst.PCPlus4M", PCPlus4M, 64'd0);
      chk("arst.RdM", {58'd0, RdM}, 64'd0);
      chk("arst.AddrModeM", {61'd0, AddrModeM}, 64'd0);
      chk("arst.ResultSrcM", {63'd0, ResultSrcM}, 64'd0);
      chk("arst.WD3SrcM", {63'd0, WD3SrcM}, 64'd0);
      $display("async reset: ValidM=%0b Occ=%0d WriteDataM=%h", ValidM, Occupancy, WriteDataM);
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      chk("arst.post.ReadyE", {63'd0, ReadyE}, 64'd1);
      chk("arst.post.Occupancy", {62'd0, Occupancy}, 64'd0);

      // ---- randomized traffic against the FIFO model ----
      last_acc = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         // An offered beat that was not taken must be held unchanged.
         if (ValidE && !last_acc) begin
            ValidE = 1'b1;
         end else begin
            ValidE = 1'($urandom);
            cur = rand_beat();
         end
         ReadyM = 1'($urandom);
         flush  = ($urandom_range(0, 63) == 0);
         cycle();
         check_model($sformatf("rnd%0d", c));
         if (c % 500 == 0)
            $display("rnd %0d: ValidE=%0b ReadyM=%0b flush=%0b Occ=%0d ValidM=%0b", c, ValidE, ReadyM, flush, Occupancy, ValidM);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
